rr_sel_arbiter: RTL and testbench

Round-robin arbiter that produces the 2-bit `sel` code for the 4:1 data multiplexer sitting directly downstream. It picks one of four requesters, holds the selection stable until the consumer signals completion or a timeout expires, and then rotates priority. A registered one-hot grant and a valid flag are provided, so requesters know when their data is on the mux output.

---
 rtl/rr_sel_arbiter.sv | 103 ++++++++++
 tb/tb_rr_sel_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter.sv
// rtl/rr_sel_arbiter.sv - four-way round-robin arbiter producing a registered 4:1 mux select
// Grants are held until done or TIMEOUT cycles, then priority rotates past the winner.
module rr_sel_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic       timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nx;
    logic [1:0]       ptr, ptr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       sel_nx;
    logic [3:0]       grant_nx;
    logic             valid_nx;
    logic             terr_nx;
    logic [1:0]       winner;
    logic [1:0]       probe;

    // Scan from the lowest-priority slot upward so the highest-priority hit lands last.
    always_comb begin
        winner = ptr;
        probe  = ptr;
        for (int k = 3; k >= 0; k--) begin
            probe = ptr + 2'(k);
            if (req[probe]) begin
                winner = probe;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        sel_nx   = sel;
        grant_nx = grant;
        valid_nx = grant_valid;
        terr_nx  = 1'b0;
        case (state)
            IDLE: begin
                grant_nx = 4'b0000;
                valid_nx = 1'b0;
                if (req != 4'b0000) begin
                    sel_nx   = winner;
                    grant_nx = 4'b0001 << winner;
                    valid_nx = 1'b1;
                    cnt_nx   = '0;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (done || (cnt == CNT_LAST)) begin
                    grant_nx = 4'b0000;
                    valid_nx = 1'b0;
                    ptr_nx   = sel + 2'd1;
                    terr_nx  = ~done;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            cnt         <= '0;
            sel         <= 2'b00;
            grant       <= 4'b0000;
            grant_valid <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            cnt         <= cnt_nx;
            sel         <= sel_nx;
            grant       <= grant_nx;
            grant_valid <= valid_nx;
            timeout_err <= terr_nx;
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb/tb_rr_sel_arbiter.sv - self-checking bench for rr_sel_arbiter
module tb_rr_sel_arbiter;

    localparam int TMO = 15;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       grant_valid;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: who holds the mux, for how many cycles so far, and who has priority.
    bit m_valid;
    bit m_terr;
    int m_sel;
    int m_ptr;
    int m_held;

    rr_sel_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .sel         (sel),
        .grant       (grant),
        .grant_valid (grant_valid),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] m_grant();
        logic [3:0] g;
        g = 4'b0000;
        if (m_valid) g[m_sel] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_terr  = 0;
        m_sel   = 0;
        m_ptr   = 0;
        m_held  = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic d);
        bit found;
        int cand;
        if (!m_valid) begin
            m_terr = 0;
            found  = 0;
            for (int k = 0; k < 4; k++) begin
                cand = (m_ptr + k) % 4;
                if (!found && r[cand]) begin
                    found  = 1;
                    m_sel  = cand;
                end
            end
            if (found) begin
                m_valid = 1;
                m_held  = 1;
            end
        end else if (d) begin
            m_valid = 0;
            m_terr  = 0;
            m_ptr   = (m_sel + 1) % 4;
        end else if (m_held == TMO) begin
            m_valid = 0;
            m_terr  = 1;
            m_ptr   = (m_sel + 1) % 4;
        end else begin
            m_held++;
            m_terr = 0;
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
    endtask

    task automatic reset_dut();
        req   = 4'b0000;
        done  = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if ({sel, grant, grant_valid, timeout_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_initial: got sel=%0d grant=%b valid=%b terr=%b, want all zero",
                     sel, grant, grant_valid, timeout_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        n_checks++;
        if (sel !== 2'd1 || grant !== 4'b0010 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_hold: got sel=%0d grant=%b valid=%b, want 1 0010 1",
                     sel, grant, grant_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({sel, grant, grant_valid, timeout_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async_hold: got sel=%0d grant=%b valid=%b terr=%b, want all zero",
                     sel, grant, grant_valid, timeout_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1'b0);
            n_checks++;
            if ({sel, grant, grant_valid, timeout_err} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_idle_stays: cycle %0d got sel=%0d grant=%b valid=%b terr=%b, want all zero",
                         i, sel, grant, grant_valid, timeout_err);
            end
        end
    endtask

    task automatic test_single();
        int vcycles;
        int terr_seen;
        vcycles   = 0;
        terr_seen = 0;
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            step(4'b0100, (i == 4));
            n_checks++;
            if (sel !== 2'(m_sel) || grant !== m_grant() || grant_valid !== m_valid || timeout_err !== m_terr) begin
                n_fail++;
                $display("FAIL single_model: cycle %0d got sel=%0d grant=%b valid=%b terr=%b, want %0d %b %b %b",
                         i, sel, grant, grant_valid, timeout_err, m_sel, m_grant(), m_valid, m_terr);
            end
            if (grant_valid) vcycles++;
            if (timeout_err) terr_seen++;
            if (i == 4) step(4'b0000, 1'b0);
            if (i == 4) break;
        end
        n_checks++;
        if (vcycles != 4 || terr_seen != 0) begin
            n_fail++;
            $display("FAIL single_duration: got valid_cycles=%0d terr=%0d, want 4 0", vcycles, terr_seen);
        end
        step(4'b1111, 1'b0);
        n_checks++;
        if (sel !== 2'd3 || grant !== 4'b1000 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ptr_rotated: got sel=%0d grant=%b valid=%b, want 3 1000 1",
                     sel, grant, grant_valid);
        end
    endtask

    task automatic test_rotation();
        int exp_seq[5];
        int got[$];
        int gap;
        bit prev_valid;
        exp_seq    = '{0, 1, 2, 3, 0};
        gap        = 0;
        prev_valid = 0;
        reset_dut();
        for (int i = 0; i < 40 && got.size() < 5; i++) begin
            step(4'b1111, (m_valid && m_held == 2));
            n_checks++;
            if (sel !== 2'(m_sel) || grant !== m_grant() || grant_valid !== m_valid || timeout_err !== m_terr) begin
                n_fail++;
                $display("FAIL rotation_model: cycle %0d got sel=%0d grant=%b valid=%b, want %0d %b %b",
                         i, sel, grant, grant_valid, m_sel, m_grant(), m_valid);
            end
            if (grant_valid && !prev_valid) begin
                if (got.size() > 0) begin
                    n_checks++;
                    if (gap != 1) begin
                        n_fail++;
                        $display("FAIL rotation_dead_cycle: got gap=%0d, want 1", gap);
                    end
                end
                got.push_back(int'(sel));
                gap = 0;
            end else if (!grant_valid) begin
                gap++;
            end
            prev_valid = grant_valid;
        end
        n_checks++;
        if (got.size() != 5) begin
            n_fail++;
            $display("FAIL rotation_count: got %0d grants, want 5", got.size());
        end
        for (int k = 0; k < got.size() && k < 5; k++) begin
            n_checks++;
            if (got[k] != exp_seq[k]) begin
                n_fail++;
                $display("FAIL rotation_seq: grant %0d got sel=%0d, want %0d", k, got[k], exp_seq[k]);
            end
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b0011, 1'b0);
        n_checks++;
        if (sel !== 2'd0 || grant !== 4'b0001 || grant_valid !== 1'b1 || sel !== 2'(m_sel)) begin
            n_fail++;
            $display("FAIL wrap_first: got sel=%0d grant=%b valid=%b, want 0 0001 1", sel, grant, grant_valid);
        end
        step(4'b0011, 1'b1);
        step(4'b0011, 1'b0);
        n_checks++;
        if (sel !== 2'd1 || grant !== 4'b0010 || grant_valid !== 1'b1 || sel !== 2'(m_sel)) begin
            n_fail++;
            $display("FAIL wrap_second: got sel=%0d grant=%b valid=%b, want 1 0010 1", sel, grant, grant_valid);
        end
    endtask

    task automatic test_timeout();
        int vcycles;
        int terr_cnt;
        vcycles  = 0;
        terr_cnt = 0;
        reset_dut();
        for (int i = 1; i <= 16; i++) begin
            step(4'b0010, 1'b0);
            if (grant_valid) vcycles++;
            if (timeout_err) begin
                terr_cnt++;
                n_checks++;
                if (grant_valid !== 1'b0 || i != 16) begin
                    n_fail++;
                    $display("FAIL timeout_pulse_timing: at step %0d got valid=%b, want step 16 valid 0", i, grant_valid);
                end
            end
        end
        n_checks++;
        if (vcycles != TMO || terr_cnt != 1) begin
            n_fail++;
            $display("FAIL timeout_duration: got valid_cycles=%0d terr_pulses=%0d, want %0d 1", vcycles, terr_cnt, TMO);
        end
        step(4'b0010, 1'b0);
        n_checks++;
        if (sel !== 2'd1 || grant_valid !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_regrant: got sel=%0d valid=%b terr=%b, want 1 1 0", sel, grant_valid, timeout_err);
        end
        for (int i = 0; i < 15; i++) step(4'b0010, 1'b0);
        step(4'b0110, 1'b0);
        n_checks++;
        if (sel !== 2'd2 || grant !== 4'b0100 || sel !== 2'(m_sel)) begin
            n_fail++;
            $display("FAIL timeout_priority: got sel=%0d grant=%b, want 2 0100", sel, grant);
        end
    endtask

    task automatic test_collision();
        reset_dut();
        for (int i = 0; i < 15; i++) step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        n_checks++;
        if (grant_valid !== 1'b0 || timeout_err !== 1'b0 || grant !== 4'b0000 || timeout_err !== m_terr) begin
            n_fail++;
            $display("FAIL collision_done_wins: got valid=%b terr=%b grant=%b, want 0 0 0000",
                     grant_valid, timeout_err, grant);
        end
        reset_dut();
        step(4'b1000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0001, 1'b0);
            n_checks++;
            if (sel !== 2'd3 || grant !== 4'b1000 || grant_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stable_req_drop: cycle %0d got sel=%0d grant=%b valid=%b, want 3 1000 1",
                         i, sel, grant, grant_valid);
            end
        end
        step(4'b0001, 1'b1);
        n_checks++;
        if (grant_valid !== 1'b0 || sel !== 2'd3) begin
            n_fail++;
            $display("FAIL stable_release: got valid=%b sel=%0d, want 0 3", grant_valid, sel);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       d;
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = 4'b0000;
            d = ($urandom_range(0, 5) == 0);
            step(r, d);
            n_checks++;
            if (sel !== 2'(m_sel) || grant !== m_grant() || grant_valid !== m_valid || timeout_err !== m_terr) begin
                n_fail++;
                $display("FAIL random_model: cycle %0d got sel=%0d grant=%b valid=%b terr=%b, want %0d %b %b %b",
                         i, sel, grant, grant_valid, timeout_err, m_sel, m_grant(), m_valid, m_terr);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_timeout();
        test_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
